// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtraction controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w-1.
  function automatic int clog2(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/response bundle between a requester and serial_sub_ctrl.
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (output start, abort, a, b, bin,
                  input  busy, done, diff, bout, zero);
  modport slave  (input  start, abort, a, b, bin,
                  output busy, done, diff, bout, zero);
endinterface

// File: rtl/serial_sub_ctrl_fsub_cell.sv
// 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: runs one fsub_cell LSB-first over WIDTH cycles.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// RUN   | one bit processed per edge, borrow carried in a flop
// DONE  | one-cycle result-valid pulse, then back to IDLE
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_sub_ctrl_if.slave bus
);

  localparam int            CW   = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, zero_q;
  logic             cell_d, cell_bo;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;

  fsub_cell u_cell (
    .x (a_sh[0]),
    .y (b_sh[0]),
    .bi(brw),
    .d (cell_d),
    .bo(cell_bo)
  );

  assign r_next   = {cell_d, r_sh[WIDTH-1:1]};
  assign last_bit = (cnt == LAST);

  // Next-state decode; abort wins over completion on the last bit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN: begin
        if (bus.abort)     state_nx = IDLE;
        else if (last_bit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand latch, serial shift datapath and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      brw    <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        brw  <= bus.bin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= r_next;
        brw  <= cell_bo;
        cnt  <= cnt + CW'(1);
        if (last_bit && !bus.abort) begin
          diff_q <= r_next;
          bout_q <= cell_bo;
          zero_q <= (r_next == '0);
        end
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH 8 and 13.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  res_t q8[$];
  res_t q13[$];
  res_t last8;

  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(8))  if8 ();
  serial_sub_ctrl_if #(.WIDTH(13)) if13 ();

  serial_sub_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_sub_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(if13));

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t ref_sub(input int w, input int a, input int b, input int bin);
    res_t r;
    int   d;
    d      = a - b - bin;
    r.diff = 16'(d & ((1 << w) - 1));
    r.bout = (a < (b + bin));
    r.zero = (r.diff == 16'd0);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitors: pop the expected result whenever a done pulse appears.
  always @(negedge clk) begin
    if (!rst && if8.done) begin
      check("done8_expected", int'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        res_t e;
        e = q8.pop_front();
        check("diff8", int'(if8.diff), int'(e.diff[7:0]));
        check("bout8", int'(if8.bout), int'(e.bout));
        check("zero8", int'(if8.zero), int'(e.zero));
        last8 = e;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if13.done) begin
      check("done13_expected", int'(q13.size() > 0), 1);
      if (q13.size() > 0) begin
        res_t e;
        e = q13.pop_front();
        check("diff13", int'(if13.diff), int'(e.diff[12:0]));
        check("bout13", int'(if13.bout), int'(e.bout));
        check("zero13", int'(if13.zero), int'(e.zero));
      end
    end
  end

  // Count negedges until done is seen (bounded); 1 = negedge right after the accepting edge.
  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if8.done && n < 40);
    check("done8_seen", int'(if8.done), 1);
  endtask

  task automatic wait_done13(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if13.done && n < 40);
    check("done13_seen", int'(if13.done), 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n;
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bin;
    q8.push_back(ref_sub(8, a, b, bin));
    @(posedge clk);
    #1 if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
    wait_done8(n);
    check("latency8", n, 9);
    @(negedge clk);
    check("done8_one_cycle", int'(if8.done), 0);
    check("busy8_after_done", int'(if8.busy), 0);
  endtask

  task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic bin);
    int n;
    @(negedge clk);
    if13.start = 1'b1; if13.a = a; if13.b = b; if13.bin = bin;
    q13.push_back(ref_sub(13, a, b, bin));
    @(posedge clk);
    #1 if13.start = 1'b0;
    wait_done13(n);
    check("latency13", n, 14);
    @(negedge clk);
    check("done13_one_cycle", int'(if13.done), 0);
  endtask

  initial begin
    int n, dones;
    rst = 1'b1;
    if8.start = 0;  if8.abort = 0;  if8.a = 0;  if8.b = 0;  if8.bin = 0;
    if13.start = 0; if13.abort = 0; if13.a = 0; if13.b = 0; if13.bin = 0;
    last8 = '{diff: 16'd0, bout: 1'b0, zero: 1'b0};
    repeat (2) @(negedge clk);
    check("rst_busy", int'(if8.busy), 0);
    check("rst_done", int'(if8.done), 0);
    check("rst_diff", int'(if8.diff), 0);
    check("rst_bout", int'(if8.bout), 0);
    check("rst_zero", int'(if8.zero), 0);
    rst = 1'b0;

    // Directed results.
    op8(8'h5A, 8'h23, 1'b0);
    op8(8'h00, 8'h01, 1'b0);
    op8(8'h10, 8'h10, 1'b1);
    op8(8'h10, 8'h10, 1'b0);

    // Second start 3 cycles into RUN is ignored.
    @(negedge clk);
    if8.start = 1; if8.a = 8'hC8; if8.b = 8'h19; if8.bin = 0;
    q8.push_back(ref_sub(8, 8'hC8, 8'h19, 0));
    @(posedge clk); #1 if8.start = 0;
    repeat (3) @(negedge clk);
    if8.start = 1; if8.a = 8'h11; if8.b = 8'h77; if8.bin = 1;
    @(negedge clk); if8.start = 0;
    wait_done8(n);
    check("ignored_start_latency", n, 5);
    repeat (12) @(negedge clk);
    check("ignored_start_idle", int'(if8.busy), 0);

    // start held high: one accept per WIDTH+2 cycles.
    @(negedge clk);
    if8.start = 1; if8.a = 8'h33; if8.b = 8'h11; if8.bin = 0;
    repeat (3) q8.push_back(ref_sub(8, 8'h33, 8'h11, 0));
    wait_done8(n);
    check("held_first_latency", n, 9);
    wait_done8(n);
    check("held_period_1", n, 10);
    wait_done8(n);
    check("held_period_2", n, 10);
    if8.start = 0;
    repeat (2) @(negedge clk);
    check("held_release_idle", int'(if8.busy), 0);

    // abort 4 cycles into RUN.
    @(negedge clk);
    if8.start = 1; if8.a = 8'h01; if8.b = 8'h02; if8.bin = 1;
    @(posedge clk); #1 if8.start = 0;
    repeat (4) @(negedge clk);
    check("abort_mid_busy_before", int'(if8.busy), 1);
    if8.abort = 1;
    @(negedge clk);
    if8.abort = 0;
    check("abort_mid_busy", int'(if8.busy), 0);
    check("abort_mid_diff", int'(if8.diff), int'(last8.diff[7:0]));
    check("abort_mid_bout", int'(if8.bout), int'(last8.bout));
    check("abort_mid_zero", int'(if8.zero), int'(last8.zero));
    dones = 0;
    repeat (12) begin @(negedge clk); if (if8.done) dones++; end
    check("abort_mid_no_done", dones, 0);

    // abort on the last-bit edge.
    @(negedge clk);
    if8.start = 1; if8.a = 8'h40; if8.b = 8'h01; if8.bin = 0;
    @(posedge clk); #1 if8.start = 0;
    repeat (8) @(negedge clk);
    if8.abort = 1;
    @(negedge clk);
    if8.abort = 0;
    check("abort_last_busy", int'(if8.busy), 0);
    check("abort_last_done", int'(if8.done), 0);
    check("abort_last_diff", int'(if8.diff), int'(last8.diff[7:0]));
    check("abort_last_bout", int'(if8.bout), int'(last8.bout));
    dones = 0;
    repeat (12) begin @(negedge clk); if (if8.done) dones++; end
    check("abort_last_no_done", dones, 0);

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    @(negedge clk);
    if8.start = 1; if8.a = 8'h99; if8.b = 8'h01; if8.bin = 0;
    @(posedge clk); #1 if8.start = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", int'(if8.busy), 0);
    check("async_rst_done", int'(if8.done), 0);
    check("async_rst_diff", int'(if8.diff), 0);
    check("async_rst_bout", int'(if8.bout), 0);
    check("async_rst_zero", int'(if8.zero), 0);
    last8 = '{diff: 16'd0, bout: 1'b0, zero: 1'b0};
    @(negedge clk); rst = 1'b0;
    op8(8'hFF, 8'h0F, 1'b1);

    // Random regression on both widths in parallel.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          op8(8'($urandom), 8'($urandom), 1'($urandom));
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          op13(13'($urandom), 13'($urandom), 1'($urandom));
        end
      end
    join

    repeat (3) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q13_drained", q13.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller. Latches two WIDTH-bit unsigned operands and a borrow-in, then drives a single 1-bit full-subtractor cell LSB-first for WIDTH cycles, carrying the borrow in a flop between cycles. It reports the difference, borrow-out and zero flag through a start/done handshake. It sits between a requester and the shared 1-bit subtractor cell, trading WIDTH cycles of latency for one cell of area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancels an operation in RUN.
- a  in  WIDTH  minuend; sampled on the accepting edge.
- b  in  WIDTH  subtrahend; sampled on the accepting edge.
- bin  in  1  borrow-in; sampled on the accepting edge.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse marking that the result is valid.
- diff  out  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  out  1  high iff a < b + bin (unsigned).
- zero  out  1  high iff diff == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start = 1:
  - latch a and b into shift registers;
  - borrow flop ← bin;
  - bit counter ← 0.
- RUN, each edge:
  - cell inputs are a_sh[0], b_sh[0] and the borrow flop;
  - the cell's difference bit shifts into the MSB of the result shift register; a_sh and b_sh shift right;
  - borrow flop ← cell borrow; counter increments.
- RUN → DONE on the edge that processes bit WIDTH−1 (counter == WIDTH−1). On that same edge:
  - diff ← final result register;
  - bout ← final borrow;
  - zero ← (final result == 0).
- DONE → IDLE unconditionally on the next edge.
- abort = 1 in RUN:
  - next state IDLE; no done pulse;
  - diff, bout and zero keep their previous values;
  - abort takes priority over completion on the last-bit edge.
- abort is ignored in IDLE and DONE.
- start is ignored in RUN and DONE (busy = 1), including start held high through DONE. A start still high when the block returns to IDLE is accepted on that IDLE edge.
- Operand inputs are don't-care except on the accepting edge.
- Results hold indefinitely until the next successful completion.
- rst (async): state IDLE, counter 0, borrow flop 0, shift registers 0, diff 0, bout 0, zero 0, busy 0, done 0. Reset mid-RUN discards the operation without a done pulse.

## Timing
- Accepting edge E0. Bits 0..WIDTH−1 are processed on edges E1..E_WIDTH.
- done = 1 and busy = 1 in the cycle after E_WIDTH. Latency from the start edge to done is WIDTH+1 cycles (9 for WIDTH = 8).
- diff, bout and zero are valid from the same cycle done rises.
- busy rises the cycle after E0 and falls the cycle after done.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- done and busy are registered (decoded from state flops); no combinational path from inputs to outputs.

## Structure
- Package serial_sub_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding);
  - counter width function clog2(WIDTH).
- One sub-module, fsub_cell: 1-bit combinational full subtractor (inputs x, y, bi; outputs d, bo). Instantiated once.
- Everything else is local to serial_sub_ctrl: FSM, counter, shift registers, borrow flop and result registers.

## Test plan
- WIDTH = 8, a = 0x5A, b = 0x23, bin = 0, start one cycle → diff = 0x37, bout = 0, zero = 0; done for exactly one cycle, 9 cycles after the start edge.
- a = 0x00, b = 0x01, bin = 0 → diff = 0xFF, bout = 1. Then a = 0x10, b = 0x10, bin = 1 → diff = 0xFF, bout = 1. Then a = 0x10, b = 0x10, bin = 0 → diff = 0x00, zero = 1, bout = 0.
- start pulsed again 3 cycles into RUN with different operands → ignored; the first result is reported. start held high continuously → operations accepted every 10 cycles.
- abort asserted 4 cycles into RUN → busy falls the next cycle, no done pulse, diff/bout/zero still hold the previous result. abort asserted on the last-bit edge → same, no done.
- rst asserted asynchronously mid-RUN → all outputs 0 immediately without waiting for an edge. After release, a fresh operation a = 0xFF, b = 0x0F, bin = 1 → diff = 0xEF, bout = 0.
- Random regression: 1000 operations with random a, b, bin at WIDTH = 8 and WIDTH = 13, compared against a reference model of (a − b − bin).
